// File: rtl/spi_tx_mode03.sv
// SPI mode 0/3 master transmitter: one word per valid/ready handshake,
// data changes on sck falling edges, far end samples on rising edges.
// Ports: clk_i, rst_i (async, active-high), cpol_i, lsbfe_i, tx_data_i,
//        tx_valid_i, tx_ready_o, sck_o, ss_n_o, data_out_o, busy_o, done_o.
module spi_tx_mode03 #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpol_i,
  input  logic              lsbfe_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              sck_o,
  output logic              ss_n_o,
  output logic              data_out_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DW-1:0]     div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              lsb_q, lsb_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
  logic              dout_q, dout_d;
  logic              done_q, done_d;
  logic              tc;

  assign tc = (div_q == DIV_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      lsb_q   <= lsb_d;
      sck_q   <= sck_d;
      ss_q    <= ss_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    lsb_d   = lsb_q;
    sck_d   = sck_q;
    ss_d    = ss_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sck_d = cpol_i;
        div_d = '0;
        bit_d = '0;
        if (tx_valid_i) begin
          sr_d    = tx_data_i;
          cpol_d  = cpol_i;
          lsb_d   = lsbfe_i;
          ss_d    = 1'b0;
          dout_d  = lsbfe_i ? tx_data_i[0]
                            : tx_data_i[DATA_W-1];
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tc) begin
          div_d   = '0;
          state_d = XFER;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      XFER: begin
        if (tc) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            bit_d = bit_q + 1'b1;
          end else if (bit_q != '0 && bit_q != BIT_LAST) begin
            // mode 3 leading fall and the final fall do not shift
            sr_d   = lsb_q ? (sr_q >> 1) : (sr_q << 1);
            dout_d = lsb_q ? sr_q[1] : sr_q[DATA_W-2];
          end
          // frame ends once all bits are clocked and sck is back idle
          if (bit_d == BIT_LAST && sck_d == cpol_q) begin
            state_d = STOP;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      STOP: begin
        if (tc) begin
          div_d   = '0;
          ss_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign sck_o      = sck_q;
  assign ss_n_o     = ss_q;
  assign data_out_o = dout_q;
  assign done_o     = done_q;

endmodule
